// File: rtl/data_mem_responder.sv
// Wait-stated data memory for a pipeline MEM stage: byte/half/word lanes, alignment faults,
// and an active-low completion strobe registered from DONE, so it shows in the cycle after DONE.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        require_mem_access,
   input  logic        write,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] data_to_mem,
   output logic        data_mem_ready_n,
   output logic [31:0] data_from_mem,
   output logic        access_fault
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t          state_reg;
   logic [3:0]      cnt_reg;
   logic            write_reg;
   logic [1:0]      size_reg;
   logic [AW+1:0]   addr_reg;
   logic [31:0]     data_reg;

   // Memory array; no reset so it maps onto block RAM. Simulation preloads through mem[].
   logic [31:0]     mem [DEPTH_WORDS];

   logic            take;
   logic            enter_done;
   logic            acc_write;
   logic [1:0]      acc_size;
   logic [AW+1:0]   acc_addr;
   logic [31:0]     acc_data;
   logic            acc_fault;
   logic            done_fault;
   logic [AW-1:0]   word_idx;
   logic [3:0]      lane_en;
   logic [31:0]     lane_data;
   logic            unused_addr_bits;

   assign unused_addr_bits = &{1'b0, addr[31:AW+2]};

   function automatic logic is_fault(input logic [1:0] sz, input logic [1:0] lo);
      return (sz == 2'b11) || (sz == 2'b01 && lo[0]) || (sz == 2'b00 && lo != 2'b00);
   endfunction

   // With zero wait states DONE is entered on the accepting edge, so the access
   // must be taken from the live inputs rather than the latched copy.
   always_comb begin
      take       = (state_reg == IDLE) && require_mem_access;
      acc_write  = write_reg;
      acc_size   = size_reg;
      acc_addr   = addr_reg;
      acc_data   = data_reg;
      if (state_reg == IDLE) begin
         acc_write = write;
         acc_size  = size;
         acc_addr  = addr[AW+1:0];
         acc_data  = data_to_mem;
      end
      enter_done = (take && (WAIT_CYCLES == 0)) || (state_reg == WAIT && cnt_reg == 4'd1);
      acc_fault  = is_fault(acc_size, acc_addr[1:0]);
      done_fault = is_fault(size_reg, addr_reg[1:0]);
      word_idx   = acc_addr[AW+1:2];
      lane_en    = 4'b1111;
      lane_data  = acc_data;
      case (acc_size)
         2'b10: begin
            lane_en   = 4'b0001 << acc_addr[1:0];
            lane_data = {4{acc_data[7:0]}};
         end
         2'b01: begin
            lane_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{acc_data[15:0]}};
         end
         default: begin
            lane_en   = 4'b1111;
            lane_data = acc_data;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst && enter_done && acc_write && !acc_fault) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
               mem[word_idx][i*8 +: 8] <= lane_data[i*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         cnt_reg          <= 4'd0;
         write_reg        <= 1'b0;
         size_reg         <= 2'b00;
         addr_reg         <= '0;
         data_reg         <= 32'd0;
         data_mem_ready_n <= 1'b1;
         data_from_mem    <= 32'd0;
         access_fault     <= 1'b0;
      end else begin
         data_mem_ready_n <= 1'b1;
         access_fault     <= 1'b0;
         if (enter_done && !acc_write) begin
            data_from_mem <= mem[word_idx];
         end
         case (state_reg)
            IDLE: begin
               if (take) begin
                  write_reg <= write;
                  size_reg  <= size;
                  addr_reg  <= addr[AW+1:0];
                  data_reg  <= data_to_mem;
                  cnt_reg   <= WAIT_INIT;
                  state_reg <= (WAIT_CYCLES == 0) ? DONE : WAIT;
               end
            end
            WAIT: begin
               cnt_reg <= cnt_reg - 4'd1;
               if (cnt_reg == 4'd1) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               data_mem_ready_n <= 1'b0;
               access_fault     <= done_fault;
               state_reg        <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a table of single accesses on a WAIT_CYCLES=2 instance,
// plus hand sequences for strobe width, held requests, reset abort and a zero-wait instance.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        wr;
   logic [1:0]  sz;
   logic [31:0] ad;
   logic [31:0] dt;
   logic        rdy_n, flt;
   logic [31:0] dfm;
   logic        rdy_n0, flt0;
   logic [31:0] dfm0;

   int checks = 0;
   int errors = 0;
   int stray  = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .require_mem_access(req), .write(wr), .size(sz),
      .addr(ad), .data_to_mem(dt), .data_mem_ready_n(rdy_n),
      .data_from_mem(dfm), .access_fault(flt)
   );

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .require_mem_access(req), .write(wr), .size(sz),
      .addr(ad), .data_to_mem(dt), .data_mem_ready_n(rdy_n0),
      .data_from_mem(dfm0), .access_fault(flt0)
   );

   typedef struct {
      bit          w;
      logic [1:0]  s;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_d;
      bit          exp_f;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   // Called on a falling edge; leaves the bench on the falling edge of the strobe cycle.
   task automatic access(input bit use0, input bit w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rdata, output logic rflt);
      req = 1'b1; wr = w; sz = s; ad = a; dt = d;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0; wr = ~w; sz = ~s; ad = ~a; dt = ~d;
      lat = -1; rdata = 32'd0; rflt = 1'b0;
      for (int k = 0; k < 24; k++) begin
         if (k > 0) @(negedge clk);
         if ((use0 ? rdy_n0 : rdy_n) == 1'b0) begin
            lat   = k;
            rdata = use0 ? dfm0 : dfm;
            rflt  = use0 ? flt0 : flt;
            break;
         end
         if ((use0 ? flt0 : flt) == 1'b1) stray++;
      end
      $display("txn use0=%0b wr=%0b sz=%02b addr=%08h data=%08h lat=%0d rd=%08h flt=%0b",
               use0, w, s, a, d, lat, rdata, rflt);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        rf;
      logic [31:0] seen;
      logic [31:0] last;
      int          pulses;

      vecs[0]  = '{1'b1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 2'b00, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 2'b00, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{1'b1, 2'b10, 32'h0000_0013, 32'h1234_56AA, 32'hDEAD_BEEF, 1'b0};
      vecs[4]  = '{1'b1, 2'b01, 32'h0000_0010, 32'hFFFF_1234, 32'hDEAD_BEEF, 1'b0};
      vecs[5]  = '{1'b0, 2'b00, 32'h0000_0010, 32'h0000_0000, 32'hAA00_1234, 1'b0};
      vecs[6]  = '{1'b1, 2'b00, 32'h0000_0020, 32'h1111_1111, 32'hAA00_1234, 1'b0};
      vecs[7]  = '{1'b1, 2'b01, 32'h0000_0021, 32'h0000_FFFF, 32'hAA00_1234, 1'b1};
      vecs[8]  = '{1'b0, 2'b00, 32'h0000_0020, 32'h0000_0000, 32'h1111_1111, 1'b0};
      vecs[9]  = '{1'b0, 2'b01, 32'h0000_0022, 32'h0000_0000, 32'h1111_1111, 1'b0};
      vecs[10] = '{1'b0, 2'b00, 32'h0000_0022, 32'h0000_0000, 32'h1111_1111, 1'b1};
      vecs[11] = '{1'b0, 2'b11, 32'h0000_0020, 32'h0000_0000, 32'h1111_1111, 1'b1};
      vecs[12] = '{1'b1, 2'b10, 32'h0000_0021, 32'h0000_005A, 32'h1111_1111, 1'b0};
      vecs[13] = '{1'b1, 2'b00, 32'h0000_0023, 32'h0000_0000, 32'h1111_1111, 1'b1};
      vecs[14] = '{1'b0, 2'b00, 32'h0000_0020, 32'h0000_0000, 32'h1111_5A11, 1'b0};
      vecs[15] = '{1'b1, 2'b01, 32'h0000_0022, 32'h0000_BEEF, 32'h1111_5A11, 1'b0};
      vecs[16] = '{1'b0, 2'b10, 32'h0000_0023, 32'h0000_0000, 32'hBEEF_5A11, 1'b0};
      vecs[17] = '{1'b1, 2'b00, 32'h0000_1030, 32'h0000_0077, 32'hBEEF_5A11, 1'b0};
      vecs[18] = '{1'b0, 2'b00, 32'h0000_0030, 32'h0000_0000, 32'h0000_0077, 1'b0};

      rst = 1'b1; req = 1'b0; wr = 1'b0; sz = 2'b00; ad = 32'd0; dt = 32'd0;
      repeat (3) @(negedge clk);
      check("reset_ready_n", {31'd0, rdy_n}, 32'd1);
      check("reset_data", dfm, 32'd0);
      check("reset_fault", {31'd0, flt}, 32'd0);
      check("reset_ready_n_w0", {31'd0, rdy_n0}, 32'd1);
      check("reset_data_w0", dfm0, 32'd0);
      rst = 1'b0;

      // First access is presented on the first edge after reset is released.
      for (int i = 0; i < 19; i++) begin
         access(1'b0, vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].d, lat, rd, rf);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
         check($sformatf("vec%0d_data", i), rd, vecs[i].exp_d);
         check($sformatf("vec%0d_fault", i), {31'd0, rf}, {31'd0, vecs[i].exp_f});
      end

      // Strobe is exactly one cycle wide.
      access(1'b0, 1'b0, 2'b00, 32'h10, 32'd0, lat, rd, rf);
      check("pw_data", rd, 32'hAA00_1234);
      @(negedge clk);
      check("pulse_width", {31'd0, rdy_n}, 32'd1);

      // Request held high for three reads: pulses 2+WAIT_CYCLES apart.
      req = 1'b1; wr = 1'b0; sz = 2'b00; ad = 32'h10; dt = 32'd0;
      seen = 32'd0; last = 32'd0;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (rdy_n == 1'b0) begin
            seen[c] = 1'b1;
            last = dfm;
         end
         if (c == 12) req = 1'b0;
      end
      $display("txn held_reads pulse_mask=%08h", seen);
      check("held_pulse_mask", seen, 32'h0000_1110);
      check("held_data", last, 32'hAA00_1234);

      // Reset one cycle after accepting a write abandons it.
      access(1'b0, 1'b1, 2'b00, 32'h40, 32'h1234_5678, lat, rd, rf);
      check("rst_prep_latency", 32'(lat), 32'd3);
      access(1'b0, 1'b0, 2'b00, 32'h40, 32'd0, lat, rd, rf);
      check("rst_prep_data", rd, 32'h1234_5678);
      req = 1'b1; wr = 1'b1; sz = 2'b00; ad = 32'h40; dt = 32'h55;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0; rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort_ready_n", {31'd0, rdy_n}, 32'd1);
      check("abort_data", dfm, 32'd0);
      check("abort_fault", {31'd0, flt}, 32'd0);
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (rdy_n == 1'b0) pulses++;
      end
      $display("txn abort_watch pulses=%0d", pulses);
      check("abort_no_pulse", 32'(pulses), 32'd0);
      access(1'b0, 1'b0, 2'b00, 32'h40, 32'd0, lat, rd, rf);
      check("abort_latency", 32'(lat), 32'd3);
      check("abort_word_kept", rd, 32'h1234_5678);

      // Zero wait states and address wrap on the second instance.
      access(1'b1, 1'b1, 2'b00, 32'h1004, 32'hCAFE_F00D, lat, rd, rf);
      check("w0_write_latency", 32'(lat), 32'd1);
      access(1'b1, 1'b0, 2'b00, 32'h4, 32'd0, lat, rd, rf);
      check("w0_read_latency", 32'(lat), 32'd1);
      check("w0_wrap_data", rd, 32'hCAFE_F00D);
      check("w0_fault", {31'd0, rf}, 32'd0);

      check("stray_fault", 32'(stray), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
